fetch_stage: RTL

Instruction fetch stage that sits directly upstream of the opcode decoder/control block. It owns the PC, issues requests to instruction memory, and holds the fetched instruction in an output register. It presents the instruction and its opcode field to decode. Taken jumps and branches from downstream redirect the PC; the stage squashes any instruction that was fetched down the wrong path.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-facing
// instruction slot and redirect inputs. master = fetch stage, slave = environment.
interface fetch_stage_if #(
  parameter int PC_W   = 12,
  parameter int INSN_W = 32
) ();
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ready;
  logic [INSN_W-1:0] imem_rdata;
  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [INSN_W-1:0] insn;
  logic [4:0]        opcode;
  logic [PC_W-1:0]   insn_pc;
  logic [PC_W-1:0]   pc_plus1;
  logic              insn_valid;

  modport master (
    output imem_req, imem_addr, insn, opcode, insn_pc, pc_plus1, insn_valid,
    input  imem_ready, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, insn, opcode, insn_pc, pc_plus1, insn_valid,
    output imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, holds it for decode.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_squashed event counters.
module fetch_stage #(
  parameter int              PC_W     = 12,
  parameter int              INSN_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_squashed
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PEND, S_DROP} state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   insn_pc_q;
  logic [INSN_W-1:0] insn_q;
  logic [INSN_W-1:0] pend_q;
  logic              insn_valid_q;

  logic              slot_free;
  logic              consume;
  logic [PC_W-1:0]   pc_inc_d;

  assign slot_free = !insn_valid_q || !bus.stall;
  assign consume   = insn_valid_q && !bus.stall && !bus.redirect;
  assign pc_inc_d  = pc_q + 1'b1;

  // A redirect cycle never issues, so the old path cannot leak a request.
  assign bus.imem_req   = (state_q == S_ISSUE) && slot_free && !bus.redirect;
  assign bus.imem_addr  = pc_q;
  assign bus.insn       = insn_q;
  assign bus.opcode     = insn_q[INSN_W-1 -: 5];
  assign bus.insn_pc    = insn_pc_q;
  assign bus.pc_plus1   = insn_pc_q + 1'b1;
  assign bus.insn_valid = insn_valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      insn_pc_q    <= '0;
      insn_q       <= '0;
      pend_q       <= '0;
      insn_valid_q <= 1'b0;
    end else if (bus.redirect) begin
      pc_q         <= bus.redirect_pc;
      insn_valid_q <= 1'b0;
      // An outstanding response still has to be swallowed before refetching.
      if ((state_q == S_WAIT || state_q == S_DROP) && !bus.imem_ready)
        state_q <= S_DROP;
      else
        state_q <= S_ISSUE;
    end else begin
      if (consume)
        insn_valid_q <= 1'b0;
      case (state_q)
        S_IDLE:  state_q <= S_ISSUE;
        S_ISSUE: if (slot_free) state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.imem_ready) begin
            pc_q <= pc_inc_d;
            if (slot_free) begin
              insn_q       <= bus.imem_rdata;
              insn_pc_q    <= pc_q;
              insn_valid_q <= 1'b1;
              state_q      <= S_ISSUE;
            end else begin
              pend_q  <= bus.imem_rdata;
              state_q <= S_PEND;
            end
          end
        end
        S_PEND: begin
          // pc already advanced past the parked word.
          if (slot_free) begin
            insn_q       <= pend_q;
            insn_pc_q    <= pc_q - 1'b1;
            insn_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_DROP:  if (bus.imem_ready) state_q <= S_ISSUE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_squashed_q;
  logic        squash_evt;

  assign squash_evt = bus.redirect &&
                      (insn_valid_q || state_q == S_PEND || state_q == S_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      if (consume)    perf_fetched_q  <= perf_fetched_q + 32'd1;
      if (squash_evt) perf_squashed_q <= perf_squashed_q + 32'd1;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule
